// File: rtl/qpu_exu_rf_wbck_arb_pkg.sv
// rtl/qpu_exu_rf_wbck_arb_pkg.sv - shared defaults and write-record type for the regfile writeback arbiter
// Contents: default data/index widths, quantum-bank select bit, {idx, data} write record.
package qpu_exu_rf_wbck_arb_pkg;

    localparam int XLEN_DEF      = 32;
    localparam int IDXW_DEF      = 6;
    // Index MSB selects the quantum-classical bank.
    localparam int QBANK_BIT_DEF = IDXW_DEF - 1;

    typedef struct packed {
        logic [IDXW_DEF-1:0] idx;
        logic [XLEN_DEF-1:0] data;
    } wbck_rec_t;

endpackage

// File: rtl/qpu_exu_rf_wbck_arb_if.sv
// rtl/qpu_exu_rf_wbck_arb_if.sv - writeback request/response bundle for the regfile arbiter
// master: requesters and regfile side (drives requests, observes ports).
// slave : arbiter side (accepts requests, drives regfile write ports).
interface qpu_exu_rf_wbck_arb_if
    import qpu_exu_rf_wbck_arb_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int IDXW = IDXW_DEF
);
    logic            alu_wbck_valid;
    logic            alu_wbck_ready;
    logic [IDXW-1:0] alu_wbck_idx;
    logic [XLEN-1:0] alu_wbck_data;

    logic            lng_wbck_valid;
    logic            lng_wbck_ready;
    logic [IDXW-1:0] lng_wbck_idx;
    logic [XLEN-1:0] lng_wbck_data;

    logic            cwbck_dest_wen;
    logic [IDXW-1:0] cwbck_dest_idx;
    logic [XLEN-1:0] cwbck_dest_data;

    logic            qcwbck_dest_wen;
    logic [IDXW-1:0] qcwbck_dest_idx;
    logic [XLEN-1:0] qcwbck_dest_data;

    logic            lng_pending;

    modport master (
        output alu_wbck_valid, alu_wbck_idx, alu_wbck_data,
        input  alu_wbck_ready,
        output lng_wbck_valid, lng_wbck_idx, lng_wbck_data,
        input  lng_wbck_ready,
        input  cwbck_dest_wen, cwbck_dest_idx, cwbck_dest_data,
        input  qcwbck_dest_wen, qcwbck_dest_idx, qcwbck_dest_data,
        input  lng_pending
    );

    modport slave (
        input  alu_wbck_valid, alu_wbck_idx, alu_wbck_data,
        output alu_wbck_ready,
        input  lng_wbck_valid, lng_wbck_idx, lng_wbck_data,
        output lng_wbck_ready,
        output cwbck_dest_wen, cwbck_dest_idx, cwbck_dest_data,
        output qcwbck_dest_wen, qcwbck_dest_idx, qcwbck_dest_data,
        output lng_pending
    );

endinterface

// File: rtl/qpu_exu_rf_wbck_fifo.sv
// rtl/qpu_exu_rf_wbck_fifo.sv - 2-deep long-pipe writeback record FIFO, no bypass
// Ports: clk, rst; push_i/push_data_i write side; pop_i/head_o read side;
// empty_o/full_o decoded from registered state only.
// Caller must never push when full nor pop when empty.
module qpu_exu_rf_wbck_fifo #(
    parameter int DW = 38
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [DW-1:0] head_o,
    output logic          empty_o,
    output logic          full_o
);

    logic [DW-1:0] ent0_q;
    logic [DW-1:0] ent1_q;
    logic          wptr_q;
    logic          rptr_q;
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;

    sirv_gnrl_dfflr #(.DW(DW)) u_ent0 (
        .lden (push_i & ~wptr_q),
        .dnxt (push_data_i),
        .qout (ent0_q),
        .clk  (clk),
        .rst  (rst)
    );

    sirv_gnrl_dfflr #(.DW(DW)) u_ent1 (
        .lden (push_i & wptr_q),
        .dnxt (push_data_i),
        .qout (ent1_q),
        .clk  (clk),
        .rst  (rst)
    );

    sirv_gnrl_dfflr #(.DW(1)) u_wptr (
        .lden (push_i),
        .dnxt (~wptr_q),
        .qout (wptr_q),
        .clk  (clk),
        .rst  (rst)
    );

    sirv_gnrl_dfflr #(.DW(1)) u_rptr (
        .lden (pop_i),
        .dnxt (~rptr_q),
        .qout (rptr_q),
        .clk  (clk),
        .rst  (rst)
    );

    // Simultaneous push and pop leaves the occupancy unchanged.
    assign cnt_d = push_i ? (cnt_q + 2'd1) : (cnt_q - 2'd1);

    sirv_gnrl_dfflr #(.DW(2)) u_cnt (
        .lden (push_i ^ pop_i),
        .dnxt (cnt_d),
        .qout (cnt_q),
        .clk  (clk),
        .rst  (rst)
    );

    assign head_o  = rptr_q ? ent1_q : ent0_q;
    assign empty_o = (cnt_q == 2'd0);
    assign full_o  = (cnt_q == 2'd2);

endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// rtl/sirv_gnrl_dfflr.sv - load-enabled flop with asynchronous active-high reset to zero
// Ports: lden (load enable), dnxt (next value), qout (stored value), clk, rst.
module sirv_gnrl_dfflr #(
    parameter int DW = 32
) (
    input  logic          lden,
    input  logic [DW-1:0] dnxt,
    output logic [DW-1:0] qout,
    input  logic          clk,
    input  logic          rst
);

    logic [DW-1:0] q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (lden) begin
            q_q <= dnxt;
        end
    end

    assign qout = q_q;

endmodule

// File: rtl/qpu_exu_rf_wbck_arb.sv
// rtl/qpu_exu_rf_wbck_arb.sv - EXU regfile write-port arbiter between ALU and long pipe
// Ports: clk, rst (async, active-high); wbck (slave modport) carrying ALU and
// long-pipe requests, classical/quantum regfile write ports and lng_pending.
// Optional: QPU_RF_WBCK_STARVE_EN adds a starvation counter forcing the long
// pipe to win after STARVE_MAX consecutive ALU wins; otherwise strict ALU priority.
module qpu_exu_rf_wbck_arb
    import qpu_exu_rf_wbck_arb_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int IDXW       = IDXW_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    qpu_exu_rf_wbck_arb_if.slave     wbck
);

    localparam int RW = IDXW + XLEN;

    logic [RW-1:0]   push_rec;
    logic [RW-1:0]   head_rec;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;

    logic            force_lng;
    logic            grant_alu;
    logic            grant_lng;
    logic            grant;
    logic [IDXW-1:0] gnt_idx;
    logic [XLEN-1:0] gnt_data;
    logic            gnt_qbank;

    logic            cwen_d,  cwen_q;
    logic [IDXW-1:0] cidx_d,  cidx_q;
    logic [XLEN-1:0] cdata_d, cdata_q;
    logic            qwen_d,  qwen_q;
    logic [IDXW-1:0] qidx_d,  qidx_q;
    logic [XLEN-1:0] qdata_d, qdata_q;

    assign fifo_push = wbck.lng_wbck_valid & ~fifo_full;
    assign push_rec  = {wbck.lng_wbck_idx, wbck.lng_wbck_data};

    qpu_exu_rf_wbck_fifo #(.DW(RW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (fifo_push),
        .push_data_i (push_rec),
        .pop_i       (fifo_pop),
        .head_o      (head_rec),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

`ifdef QPU_RF_WBCK_STARVE_EN
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;

    // Counter only reaches max while the FIFO holds the starved entry; the
    // empty qualifier just keeps a forced grant from ever popping nothing.
    assign force_lng = (starve_cnt_q == CNT_MAX) & ~fifo_empty;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (fifo_pop || fifo_empty) begin
            starve_cnt_d = '0;
        end else if (grant_alu && (starve_cnt_q != CNT_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_lng = 1'b0;
`endif

    assign grant_alu = ~force_lng & wbck.alu_wbck_valid;
    assign grant_lng = force_lng | (~wbck.alu_wbck_valid & ~fifo_empty);
    assign grant     = grant_alu | grant_lng;
    assign fifo_pop  = grant_lng;

    assign gnt_idx   = grant_lng ? head_rec[RW-1:XLEN] : wbck.alu_wbck_idx;
    assign gnt_data  = grant_lng ? head_rec[XLEN-1:0]  : wbck.alu_wbck_data;
    assign gnt_qbank = gnt_idx[IDXW-1];

    // A classical write to idx 0 is consumed with no enable raised.
    always_comb begin
        cwen_d  = grant & ~gnt_qbank & (gnt_idx != '0);
        qwen_d  = grant & gnt_qbank;
        cidx_d  = cidx_q;
        cdata_d = cdata_q;
        qidx_d  = qidx_q;
        qdata_d = qdata_q;
        if (cwen_d) begin
            cidx_d  = gnt_idx;
            cdata_d = gnt_data;
        end
        if (qwen_d) begin
            qidx_d  = gnt_idx;
            qdata_d = gnt_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cwen_q  <= 1'b0;
            cidx_q  <= '0;
            cdata_q <= '0;
            qwen_q  <= 1'b0;
            qidx_q  <= '0;
            qdata_q <= '0;
        end else begin
            cwen_q  <= cwen_d;
            cidx_q  <= cidx_d;
            cdata_q <= cdata_d;
            qwen_q  <= qwen_d;
            qidx_q  <= qidx_d;
            qdata_q <= qdata_d;
        end
    end

    assign wbck.alu_wbck_ready   = ~force_lng;
    assign wbck.lng_wbck_ready   = ~fifo_full;
    assign wbck.lng_pending      = ~fifo_empty;
    assign wbck.cwbck_dest_wen   = cwen_q;
    assign wbck.cwbck_dest_idx   = cidx_q;
    assign wbck.cwbck_dest_data  = cdata_q;
    assign wbck.qcwbck_dest_wen  = qwen_q;
    assign wbck.qcwbck_dest_idx  = qidx_q;
    assign wbck.qcwbck_dest_data = qdata_q;

endmodule

// File: tb/tb_qpu_exu_rf_wbck_arb.sv
// tb/tb_qpu_exu_rf_wbck_arb.sv - directed self-checking bench for qpu_exu_rf_wbck_arb
module tb_qpu_exu_rf_wbck_arb;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic rdy_exp [9];
    logic qw_exp  [9];

    qpu_exu_rf_wbck_arb_if #(.XLEN(32), .IDXW(6)) bus ();

    qpu_exu_rf_wbck_arb #(.XLEN(32), .IDXW(6), .STARVE_MAX(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .wbck (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.alu_wbck_valid = 1'b0;
        bus.alu_wbck_idx   = '0;
        bus.alu_wbck_data  = '0;
        bus.lng_wbck_valid = 1'b0;
        bus.lng_wbck_idx   = '0;
        bus.lng_wbck_data  = '0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_cwen",    32'(bus.cwbck_dest_wen),  32'd0);
        chk("rst_qwen",    32'(bus.qcwbck_dest_wen), 32'd0);
        chk("rst_cidx",    32'(bus.cwbck_dest_idx),  32'd0);
        chk("rst_cdata",   bus.cwbck_dest_data,      32'd0);
        chk("rst_lrdy",    32'(bus.lng_wbck_ready),  32'd1);
        chk("rst_ardy",    32'(bus.alu_wbck_ready),  32'd1);
        chk("rst_pending", 32'(bus.lng_pending),     32'd0);
        tick();
        chk("idle_cwen", 32'(bus.cwbck_dest_wen),  32'd0);
        chk("idle_qwen", 32'(bus.qcwbck_dest_wen), 32'd0);

        // ALU write idx 5
        bus.alu_wbck_valid = 1'b1;
        bus.alu_wbck_idx   = 6'd5;
        bus.alu_wbck_data  = 32'hDEADBEEF;
        tick();
        chk("alu_cwen",  32'(bus.cwbck_dest_wen),  32'd1);
        chk("alu_cidx",  32'(bus.cwbck_dest_idx),  32'd5);
        chk("alu_cdata", bus.cwbck_dest_data,      32'hDEADBEEF);
        chk("alu_qwen",  32'(bus.qcwbck_dest_wen), 32'd0);
        // ALU write idx 0 is consumed silently
        bus.alu_wbck_idx  = 6'd0;
        bus.alu_wbck_data = 32'h12345678;
        tick();
        chk("alu0_cwen", 32'(bus.cwbck_dest_wen),  32'd0);
        chk("alu0_qwen", 32'(bus.qcwbck_dest_wen), 32'd0);
        bus.alu_wbck_valid = 1'b0;
        tick();
        chk("alu_done_cwen", 32'(bus.cwbck_dest_wen), 32'd0);

        // Long-pipe write to quantum bank: push, pop, then write
        bus.lng_wbck_valid = 1'b1;
        bus.lng_wbck_idx   = 6'b100011;
        bus.lng_wbck_data  = 32'h1;
        tick();
        bus.lng_wbck_valid = 1'b0;
        chk("lng_push_pending", 32'(bus.lng_pending),     32'd1);
        chk("lng_push_qwen",    32'(bus.qcwbck_dest_wen), 32'd0);
        tick();
        chk("lng_qwen",    32'(bus.qcwbck_dest_wen),  32'd1);
        chk("lng_qidx",    32'(bus.qcwbck_dest_idx),  32'd35);
        chk("lng_qdata",   bus.qcwbck_dest_data,      32'h1);
        chk("lng_cwen",    32'(bus.cwbck_dest_wen),   32'd0);
        chk("lng_pending", 32'(bus.lng_pending),      32'd0);
        tick();
        chk("lng_qwen_once", 32'(bus.qcwbck_dest_wen), 32'd0);

        // Two long-pipe pushes while the ALU stays busy
        bus.alu_wbck_valid = 1'b1;
        bus.alu_wbck_idx   = 6'd1;
        bus.alu_wbck_data  = 32'h1111;
        bus.lng_wbck_valid = 1'b1;
        bus.lng_wbck_idx   = 6'b100001;
        bus.lng_wbck_data  = 32'hA1;
        tick();
        bus.lng_wbck_idx   = 6'b100010;
        bus.lng_wbck_data  = 32'hA2;
        tick();
        bus.lng_wbck_valid = 1'b0;
        chk("full_lrdy",    32'(bus.lng_wbck_ready), 32'd0);
        chk("full_pending", 32'(bus.lng_pending),    32'd1);
        chk("full_ardy",    32'(bus.alu_wbck_ready), 32'd1);
        chk("full_cwen",    32'(bus.cwbck_dest_wen), 32'd1);

`ifdef QPU_RF_WBCK_STARVE_EN
        rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        qw_exp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("starve_ardy_%0d", i), 32'(bus.alu_wbck_ready),  32'(rdy_exp[i]));
            chk($sformatf("starve_qwen_%0d", i), 32'(bus.qcwbck_dest_wen), 32'(qw_exp[i]));
            if (qw_exp[i]) begin
                chk($sformatf("starve_qidx_%0d", i), 32'(bus.qcwbck_dest_idx),
                    (i == 3) ? 32'd33 : 32'd34);
                chk($sformatf("starve_cwen_%0d", i), 32'(bus.cwbck_dest_wen), 32'd0);
            end
        end
        chk("starve_drained", 32'(bus.lng_pending), 32'd0);
        bus.alu_wbck_valid = 1'b0;
        tick();
        chk("starve_idle_qwen", 32'(bus.qcwbck_dest_wen), 32'd0);
`else
        rdy_exp = '{default: 1'b1};
        qw_exp  = '{default: 1'b0};
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("strict_ardy_%0d", i),    32'(bus.alu_wbck_ready),  32'(rdy_exp[i]));
            chk($sformatf("strict_qwen_%0d", i),    32'(bus.qcwbck_dest_wen), 32'(qw_exp[i]));
            chk($sformatf("strict_pending_%0d", i), 32'(bus.lng_pending),     32'd1);
            chk($sformatf("strict_lrdy_%0d", i),    32'(bus.lng_wbck_ready),  32'd0);
        end
        bus.alu_wbck_valid = 1'b0;
        tick();
        chk("drain1_qwen", 32'(bus.qcwbck_dest_wen), 32'd1);
        chk("drain1_qidx", 32'(bus.qcwbck_dest_idx), 32'd33);
        chk("drain1_lrdy", 32'(bus.lng_wbck_ready),  32'd1);
        tick();
        chk("drain2_qwen",    32'(bus.qcwbck_dest_wen), 32'd1);
        chk("drain2_qidx",    32'(bus.qcwbck_dest_idx), 32'd34);
        chk("drain2_qdata",   bus.qcwbck_dest_data,     32'hA2);
        chk("drain2_pending", 32'(bus.lng_pending),     32'd0);
        tick();
        chk("drain_idle_qwen", 32'(bus.qcwbck_dest_wen), 32'd0);
`endif

        // Reset with FIFO full and a classical write in flight
        bus.alu_wbck_valid = 1'b1;
        bus.alu_wbck_idx   = 6'd7;
        bus.alu_wbck_data  = 32'h77;
        bus.lng_wbck_valid = 1'b1;
        bus.lng_wbck_idx   = 6'b100100;
        bus.lng_wbck_data  = 32'hB1;
        tick();
        tick();
        chk("pre_rst_cwen", 32'(bus.cwbck_dest_wen), 32'd1);
        chk("pre_rst_lrdy", 32'(bus.lng_wbck_ready), 32'd0);
        rst = 1'b1;
        bus.alu_wbck_valid = 1'b0;
        bus.lng_wbck_valid = 1'b0;
        #1;
        chk("mid_rst_cwen",    32'(bus.cwbck_dest_wen),  32'd0);
        chk("mid_rst_qwen",    32'(bus.qcwbck_dest_wen), 32'd0);
        chk("mid_rst_pending", 32'(bus.lng_pending),     32'd0);
        chk("mid_rst_lrdy",    32'(bus.lng_wbck_ready),  32'd1);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_cwen",    32'(bus.cwbck_dest_wen),  32'd0);
        chk("post_rst_qwen",    32'(bus.qcwbck_dest_wen), 32'd0);
        chk("post_rst_pending", 32'(bus.lng_pending),     32'd0);
        tick();
        chk("post_rst2_cwen", 32'(bus.cwbck_dest_wen),  32'd0);
        chk("post_rst2_qwen", 32'(bus.qcwbck_dest_wen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
